// File: rtl/x_counter_pkg.sv
// Shared types and helpers for the x_counter_updown family.
// Optional prescaler is enabled by defining X_COUNTER_PRESCALE_EN.
package x_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } counter_mode_e;

    // All-ones value for a counter of the given width (width up to 63).
    function automatic logic [63:0] count_max(input int unsigned width);
        logic [63:0] v;
        v = 64'd0;
        for (int unsigned b = 0; b < 64; b++) begin
            if (b < width) begin
                v[b] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/x_counter_prescale.sv
// Divide-by-DIV enable prescaler: phase advances on enabled cycles only and
// o_tick is high while the phase sits at its last value.
module x_counter_prescale
    import x_counter_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);

    logic [PW-1:0] r_phase;
    logic          w_at_last;

    assign w_at_last = (r_phase == PHASE_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (i_restart) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= w_at_last ? '0 : r_phase + PW'(1);
        end
    end

    assign o_tick = w_at_last;

endmodule

// File: rtl/x_counter_updown.sv
// Parametrised up/down counter with wrap/saturate modes, clear, load and flags.
// Define X_COUNTER_PRESCALE_EN to gate stepping with a divide-by-DIV prescaler.
module x_counter_updown
    import x_counter_pkg::*;
#(
    parameter int unsigned   WIDTH = 8,
    parameter counter_mode_e MODE  = MODE_WRAP,
    parameter int unsigned   DIV   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_sat,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(count_max(WIDTH));
    localparam logic             IS_SAT  = (MODE == MODE_SAT);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("x_counter_updown: WIDTH must be at least 2");
        end
        if (DIV < 2) begin : g_bad_div
            $error("x_counter_updown: DIV must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_sat;
    logic             r_zero;

    logic             w_tick;
    logic             w_step;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_tc;
    logic             w_next_sat;

`ifdef X_COUNTER_PRESCALE_EN
    // Clear and load restart the phase so stepping is aligned to the new value.
    x_counter_prescale #(
        .DIV (DIV)
    ) u_prescale (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_restart (i_clr | i_load),
        .o_tick    (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    assign w_step = i_en & w_tick;
    assign w_inc  = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec  = {1'b0, r_count} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_next_count = r_count;
        w_next_tc    = 1'b0;
        w_next_sat   = r_sat;
        if (i_clr) begin
            w_next_count = '0;
            w_next_sat   = 1'b0;
        end else if (i_load) begin
            w_next_count = i_load_val;
            w_next_sat   = IS_SAT && ((i_load_val == '0) || (i_load_val == CNT_MAX));
        end else if (w_step) begin
            if (i_up) begin
                if (!IS_SAT) begin
                    w_next_count = w_inc[WIDTH-1:0];
                    w_next_tc    = w_inc[WIDTH];
                end else if (r_count == CNT_MAX) begin
                    w_next_sat   = 1'b1;
                end else begin
                    w_next_count = w_inc[WIDTH-1:0];
                    w_next_tc    = (w_inc[WIDTH-1:0] == CNT_MAX);
                    w_next_sat   = (w_inc[WIDTH-1:0] == CNT_MAX);
                end
            end else begin
                if (!IS_SAT) begin
                    w_next_count = w_dec[WIDTH-1:0];
                    w_next_tc    = w_dec[WIDTH];
                end else if (r_count == '0) begin
                    w_next_sat   = 1'b1;
                end else begin
                    w_next_count = w_dec[WIDTH-1:0];
                    w_next_tc    = (w_dec[WIDTH-1:0] == '0);
                    w_next_sat   = (w_dec[WIDTH-1:0] == '0);
                end
            end
        end
    end

    // Flags are registered from the next count so they line up with o_count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_sat   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_count <= w_next_count;
            r_tc    <= w_next_tc;
            r_sat   <= w_next_sat;
            r_zero  <= (w_next_count == '0);
        end
    end

    assign o_count = r_count;
    assign o_tc    = r_tc;
    assign o_sat   = IS_SAT ? r_sat : 1'b0;
    assign o_zero  = r_zero;

endmodule

// File: tb/tb_x_counter_updown.sv
// Directed bench for x_counter_updown: one WRAP and one SAT instance share inputs.
// The prescaler sequence runs when X_COUNTER_PRESCALE_EN is defined.
module tb_x_counter_updown;
    import x_counter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] w_count;
    logic       w_tc;
    logic       w_sat;
    logic       w_zero;
    logic [7:0] s_count;
    logic       s_tc;
    logic       s_sat;
    logic       s_zero;

    int checks;
    int failures;

    x_counter_updown #(.WIDTH(8), .MODE(MODE_WRAP), .DIV(4)) u_wrap (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_up       (up),
        .i_clr      (clr),
        .i_load     (load),
        .i_load_val (load_val),
        .o_count    (w_count),
        .o_tc       (w_tc),
        .o_sat      (w_sat),
        .o_zero     (w_zero)
    );

    x_counter_updown #(.WIDTH(8), .MODE(MODE_SAT), .DIV(4)) u_sat (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_up       (up),
        .i_clr      (clr),
        .i_load     (load),
        .i_load_val (load_val),
        .o_count    (s_count),
        .o_tc       (s_tc),
        .o_sat      (s_sat),
        .o_zero     (s_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] dn_w[7];
        logic [7:0] dn_s[7];
        logic [7:0] sup_w[5];
        logic [7:0] sup_s[5];
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        dn_w  = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
        dn_s  = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
        sup_w = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        sup_s = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        // Reset state
        tick();
        tick();
        check("rst_w_count", 32'(w_count), 32'h00);
        check("rst_w_tc",    32'(w_tc),    32'h0);
        check("rst_w_sat",   32'(w_sat),   32'h0);
        check("rst_w_zero",  32'(w_zero),  32'h1);
        check("rst_s_count", 32'(s_count), 32'h00);
        check("rst_s_sat",   32'(s_sat),   32'h0);
        check("rst_s_zero",  32'(s_zero),  32'h1);

`ifdef X_COUNTER_PRESCALE_EN
        // One step per four enabled cycles
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("pre_count", 32'(w_count), 32'(k / 4));
            check("pre_tc",    32'(w_tc),    32'h0);
        end
        tick();
        tick();
        check("pre_mid_count", 32'(w_count), 32'h03);
        en = 1'b0;
        tick();
        tick();
        check("pre_pause_count", 32'(w_count), 32'h03);
        en = 1'b1;
        tick();
        check("pre_delay_count", 32'(w_count), 32'h03);
        tick();
        check("pre_resume_count", 32'(w_count), 32'h04);
        check("pre_resume_s_count", 32'(s_count), 32'h04);
`else
        // Full up sweep: WRAP wraps after 256 steps, SAT clamps at 0xFF
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            check("up_w_count", 32'(w_count), 32'(i));
            check("up_w_tc",    32'(w_tc),    32'h0);
            check("up_w_zero",  32'(w_zero),  32'h0);
            check("up_s_count", 32'(s_count), 32'(i));
            check("up_s_tc",    32'(s_tc),    32'(i == 255));
            check("up_s_sat",   32'(s_sat),   32'(i == 255));
        end
        tick();
        check("wrap_w_count", 32'(w_count), 32'h00);
        check("wrap_w_tc",    32'(w_tc),    32'h1);
        check("wrap_w_zero",  32'(w_zero),  32'h1);
        check("hold_s_count", 32'(s_count), 32'hFF);
        check("hold_s_tc",    32'(s_tc),    32'h0);
        check("hold_s_sat",   32'(s_sat),   32'h1);

        // Load 0x05 then count down through zero
        load     = 1'b1;
        load_val = 8'h05;
        tick();
        check("ld5_w_count", 32'(w_count), 32'h05);
        check("ld5_w_tc",    32'(w_tc),    32'h0);
        check("ld5_s_count", 32'(s_count), 32'h05);
        check("ld5_s_sat",   32'(s_sat),   32'h0);
        load = 1'b0;
        up   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("dn_w_count", 32'(w_count), 32'(dn_w[i]));
            check("dn_w_tc",    32'(w_tc),    32'(i == 5));
            check("dn_w_zero",  32'(w_zero),  32'(i == 4));
            check("dn_s_count", 32'(s_count), 32'(dn_s[i]));
            check("dn_s_tc",    32'(s_tc),    32'(i == 4));
            check("dn_s_sat",   32'(s_sat),   32'(i >= 4));
        end

        // Load 0xFD then count up into the top limit
        load     = 1'b1;
        load_val = 8'hFD;
        up       = 1'b1;
        tick();
        check("ldfd_s_count", 32'(s_count), 32'hFD);
        check("ldfd_s_sat",   32'(s_sat),   32'h0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sup_w_count", 32'(w_count), 32'(sup_w[i]));
            check("sup_w_tc",    32'(w_tc),    32'(i == 2));
            check("sup_s_count", 32'(s_count), 32'(sup_s[i]));
            check("sup_s_tc",    32'(s_tc),    32'(i == 1));
            check("sup_s_sat",   32'(s_sat),   32'(i >= 1));
        end
        up = 1'b0;
        tick();
        check("leave_s_count", 32'(s_count), 32'hFE);
        check("leave_s_sat",   32'(s_sat),   32'h0);
        check("leave_s_tc",    32'(s_tc),    32'h0);
        check("leave_w_count", 32'(w_count), 32'h01);

        // Loading a limit value raises o_sat without o_tc
        load     = 1'b1;
        load_val = 8'hFF;
        tick();
        check("ldff_s_sat",   32'(s_sat),   32'h1);
        check("ldff_s_tc",    32'(s_tc),    32'h0);
        check("ldff_w_count", 32'(w_count), 32'hFF);
        check("ldff_w_sat",   32'(w_sat),   32'h0);

        // Clear beats load and step
        clr      = 1'b1;
        load_val = 8'h33;
        tick();
        check("clr_w_count", 32'(w_count), 32'h00);
        check("clr_w_tc",    32'(w_tc),    32'h0);
        check("clr_w_zero",  32'(w_zero),  32'h1);
        check("clr_s_count", 32'(s_count), 32'h00);
        check("clr_s_sat",   32'(s_sat),   32'h0);
        clr      = 1'b0;
        load_val = 8'h00;
        tick();
        check("ld0_s_sat",  32'(s_sat),  32'h1);
        check("ld0_s_zero", 32'(s_zero), 32'h1);

        // Enable low holds the count
        load_val = 8'h10;
        en       = 1'b0;
        up       = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        check("hold_w_count", 32'(w_count), 32'h10);
        check("hold_w_tc",    32'(w_tc),    32'h0);
        check("hold_s_count2", 32'(s_count), 32'h10);

        // Reset in the middle of counting
        en       = 1'b1;
        load     = 1'b1;
        load_val = 8'h7F;
        tick();
        load = 1'b0;
        tick();
        check("pre_rst_w_count", 32'(w_count), 32'h80);
        check("pre_rst_s_count", 32'(s_count), 32'h80);
        rst_n = 1'b0;
        tick();
        check("mid_rst_w_count", 32'(w_count), 32'h00);
        check("mid_rst_w_tc",    32'(w_tc),    32'h0);
        check("mid_rst_w_zero",  32'(w_zero),  32'h1);
        check("mid_rst_s_sat",   32'(s_sat),   32'h0);
        rst_n = 1'b1;
        tick();
        check("resume_w_count", 32'(w_count), 32'h01);
        check("resume_w_zero",  32'(w_zero),  32'h0);
        check("resume_s_count", 32'(s_count), 32'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
